// File: rtl/tdr_pkg.sv
// Shared definitions for the time-redundant flip-flop mode controller:
// the 3-bit state encoding and the default parameter values.
package tdr_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL  = 3'd0,
    ST_ARM     = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RECOVER = 3'd3,
    ST_FAULT   = 3'd4
  } tdr_state_e;

  localparam int DEF_NUM_FF     = 8;
  localparam int DEF_CNT_W      = 4;
  localparam int DEF_ERR_THRESH = 3;
  localparam int DEF_REC_CYCLES = 2;

endpackage

// File: rtl/tdr_err_counter.sv
// Saturating error counter with a clear that overrides increment, plus a
// look-ahead flag telling whether an increment would reach the threshold.
module tdr_err_counter
  import tdr_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int THRESH = DEF_ERR_THRESH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             thresh_on_inc
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_inc;
    end
  end

  assign cnt           = cnt_reg;
  assign thresh_on_inc = (cnt_inc >= THRESH_C);

endmodule

// File: rtl/tdr_mode_ctrl.sv
// Mode controller for a bank of time-redundant flip-flops: sequences
// normal/arm/check/recover/fault, counts errors and logs failing blocks.
module tdr_mode_ctrl
  import tdr_pkg::*;
#(
  parameter int NUM_FF     = DEF_NUM_FF,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ERR_THRESH = DEF_ERR_THRESH,
  parameter int REC_CYCLES = DEF_REC_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tdr_en,
  input  logic              clear,
  input  logic [NUM_FF-1:0] fail_vec,
  output logic              modeS,
  output logic              stall,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [NUM_FF-1:0] fail_log,
  output logic              fault,
  output logic [2:0]        state_o
);

  // Recovery down-counter is loaded with REC_CYCLES-1 so RECOVER lasts REC_CYCLES cycles.
  localparam int              REC_W    = (REC_CYCLES > 1) ? $clog2(REC_CYCLES) : 1;
  localparam logic [REC_W-1:0] REC_LOAD = REC_W'(REC_CYCLES - 1);

  tdr_state_e        state_reg, state_next;
  logic [REC_W-1:0]  rec_reg, rec_next;
  logic              err_pulse_reg;
  logic [NUM_FF-1:0] fail_log_reg, fail_log_next;
  logic              fail_any;
  logic              accept;
  logic              thresh_on_inc;

  assign fail_any = |fail_vec;
  assign accept   = (state_reg == ST_CHECK) && fail_any;

  tdr_err_counter #(
    .CNT_W (CNT_W),
    .THRESH(ERR_THRESH)
  ) u_err_counter (
    .clk          (clk),
    .rst          (rst),
    .inc          (accept),
    .clr          (clear),
    .cnt          (err_cnt),
    .thresh_on_inc(thresh_on_inc)
  );

  always_comb begin
    state_next    = state_reg;
    rec_next      = rec_reg;
    fail_log_next = fail_log_reg;

    if (clear) begin
      fail_log_next = '0;
    end else if (accept) begin
      fail_log_next = fail_log_reg | fail_vec;
    end

    case (state_reg)
      ST_NORMAL: begin
        if (tdr_en) state_next = ST_ARM;
      end
      ST_ARM: begin
        state_next = tdr_en ? ST_CHECK : ST_NORMAL;
      end
      ST_CHECK: begin
        // An error beats a simultaneous drop of tdr_en; a clear suppresses escalation.
        if (fail_any) begin
          rec_next   = REC_LOAD;
          state_next = (!clear && thresh_on_inc) ? ST_FAULT : ST_RECOVER;
        end else if (!tdr_en) begin
          state_next = ST_NORMAL;
        end
      end
      ST_RECOVER: begin
        if (rec_reg == '0) begin
          state_next = tdr_en ? ST_CHECK : ST_NORMAL;
        end else begin
          rec_next = rec_reg - 1'b1;
        end
      end
      ST_FAULT: begin
        if (clear) state_next = ST_NORMAL;
      end
      default: state_next = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_NORMAL;
      rec_reg       <= '0;
      err_pulse_reg <= 1'b0;
      fail_log_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      rec_reg       <= rec_next;
      err_pulse_reg <= accept;
      fail_log_reg  <= fail_log_next;
    end
  end

  assign modeS     = (state_reg == ST_NORMAL) || (state_reg == ST_FAULT);
  assign stall     = (state_reg == ST_RECOVER);
  assign fault     = (state_reg == ST_FAULT);
  assign err_pulse = err_pulse_reg;
  assign fail_log  = fail_log_reg;
  assign state_o   = state_reg;

endmodule

// File: tb/tb_tdr_mode_ctrl.sv
// Directed bench for tdr_mode_ctrl: a behavioural model is checked against the
// DUT every cycle, with literal expectations pinning key points of each scenario.
module tb_tdr_mode_ctrl;

  localparam int NUM_FF = 8;
  localparam int CNT_W  = 4;
  localparam int THRESH = 3;
  localparam int REC    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tdr_en = 1'b0;
  logic              clear = 1'b0;
  logic [NUM_FF-1:0] fail_vec = '0;
  logic              modeS, stall, err_pulse, fault;
  logic [CNT_W-1:0]  err_cnt;
  logic [NUM_FF-1:0] fail_log;
  logic [2:0]        state_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tdr_mode_ctrl #(
    .NUM_FF(NUM_FF), .CNT_W(CNT_W), .ERR_THRESH(THRESH), .REC_CYCLES(REC)
  ) dut (
    .clk(clk), .rst(rst), .tdr_en(tdr_en), .clear(clear), .fail_vec(fail_vec),
    .modeS(modeS), .stall(stall), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .fail_log(fail_log), .fault(fault), .state_o(state_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: phase 0 idle, 1 arming, 2 watching, 3 recovering, 4 faulted.
  int m_phase = 0, m_left = 0, m_errs = 0, m_log = 0, m_pulse = 0;
  bit m_valid = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_phase = 0; m_left = 0; m_errs = 0; m_log = 0; m_pulse = 0; m_valid = 1;
      end else begin
        m_pulse = (m_phase == 2 && fail_vec != 0) ? 1 : 0;
        if (clear) begin
          m_errs = 0;
          m_log  = 0;
        end
        if (m_phase == 0) begin
          if (tdr_en) m_phase = 1;
        end else if (m_phase == 1) begin
          m_phase = tdr_en ? 2 : 0;
        end else if (m_phase == 2) begin
          if (fail_vec != 0) begin
            if (!clear) begin
              m_errs = (m_errs + 1 > 15) ? 15 : m_errs + 1;
              m_log  = m_log | int'(fail_vec);
            end
            if (!clear && m_errs >= THRESH) m_phase = 4;
            else begin
              m_phase = 3;
              m_left  = REC;
            end
          end else if (!tdr_en) m_phase = 0;
        end else if (m_phase == 3) begin
          m_left = m_left - 1;
          if (m_left == 0) m_phase = tdr_en ? 2 : 0;
        end else begin
          if (clear) m_phase = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("state_o",   int'(state_o),   m_phase);
        chk("modeS",     int'(modeS),     (m_phase == 0 || m_phase == 4) ? 1 : 0);
        chk("stall",     int'(stall),     (m_phase == 3) ? 1 : 0);
        chk("fault",     int'(fault),     (m_phase == 4) ? 1 : 0);
        chk("err_pulse", int'(err_pulse), m_pulse);
        chk("err_cnt",   int'(err_cnt),   m_errs);
        chk("fail_log",  int'(fail_log),  m_log);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] err_bits [3] = '{8'h01, 8'h02, 8'h80};

  initial begin
    // Reset and idle
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("idle_state", int'(state_o), 0);
      chk("idle_modeS", int'(modeS), 1);
      chk("idle_stall", int'(stall), 0);
      chk("idle_cnt",   int'(err_cnt), 0);
    end
    $display("idle: state=%0d modeS=%0b", state_o, modeS);

    // Enter checking, with a masked failure during ARM
    tdr_en = 1'b1; fail_vec = 8'h01;
    step(1);
    chk("arm_state", int'(state_o), 1);
    chk("arm_modeS", int'(modeS), 0);
    step(1);
    fail_vec = 8'h00;
    chk("check_state", int'(state_o), 2);
    chk("arm_no_pulse", int'(err_pulse), 0);
    step(1);
    chk("check_no_pulse", int'(err_pulse), 0);
    $display("enter check: state=%0d err_pulse=%0b", state_o, err_pulse);

    // Single error
    fail_vec = 8'h24;
    step(1);
    fail_vec = 8'h00;
    chk("err1_pulse", int'(err_pulse), 1);
    chk("err1_cnt",   int'(err_cnt), 1);
    chk("err1_log",   int'(fail_log), 8'h24);
    chk("err1_stall", int'(stall), 1);
    step(1);
    chk("err1_stall2", int'(stall), 1);
    chk("err1_pulse_off", int'(err_pulse), 0);
    step(1);
    chk("err1_stall_off", int'(stall), 0);
    chk("err1_back_check", int'(state_o), 2);
    $display("single error: cnt=%0d log=%02h", err_cnt, fail_log);

    // Clear outside FAULT keeps the state
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_cnt", int'(err_cnt), 0);
    chk("clr_log", int'(fail_log), 0);
    chk("clr_state", int'(state_o), 2);

    // Threshold: three separated errors
    for (int k = 0; k < 3; k++) begin
      fail_vec = err_bits[k];
      step(1);
      fail_vec = 8'h00;
      chk("thr_pulse", int'(err_pulse), 1);
      chk("thr_cnt", int'(err_cnt), k + 1);
      if (k < 2) step(2);
      $display("threshold error %0d: cnt=%0d state=%0d", k, err_cnt, state_o);
    end
    chk("fault_state", int'(state_o), 4);
    chk("fault_flag",  int'(fault), 1);
    chk("fault_modeS", int'(modeS), 1);
    chk("fault_log",   int'(fail_log), 8'h83);
    fail_vec = 8'hFF;
    step(3);
    fail_vec = 8'h00;
    chk("fault_hold_cnt", int'(err_cnt), 3);
    chk("fault_hold_log", int'(fail_log), 8'h83);
    chk("fault_hold_state", int'(state_o), 4);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("unfault_flag",  int'(fault), 0);
    chk("unfault_cnt",   int'(err_cnt), 0);
    chk("unfault_state", int'(state_o), 0);
    $display("fault cleared: state=%0d fault=%0b", state_o, fault);

    // Reset during the second stall cycle
    step(2);
    chk("rearm_state", int'(state_o), 2);
    fail_vec = 8'h04;
    step(1);
    fail_vec = 8'h00;
    chk("rec1_stall", int'(stall), 1);
    step(1);
    chk("rec2_stall", int'(stall), 1);
    rst = 1'b1;
    step(1);
    chk("rstrec_stall", int'(stall), 0);
    chk("rstrec_modeS", int'(modeS), 1);
    chk("rstrec_cnt",   int'(err_cnt), 0);
    chk("rstrec_state", int'(state_o), 0);
    $display("reset mid-recovery: state=%0d stall=%0b", state_o, stall);
    rst = 1'b0;

    // Error, tdr_en drop and clear all in the same CHECK cycle
    step(2);
    chk("sim_pre_state", int'(state_o), 2);
    fail_vec = 8'h10; tdr_en = 1'b0; clear = 1'b1;
    step(1);
    fail_vec = 8'h00; clear = 1'b0;
    chk("sim_pulse", int'(err_pulse), 1);
    chk("sim_cnt",   int'(err_cnt), 0);
    chk("sim_state", int'(state_o), 3);
    step(2);
    chk("sim_exit_state", int'(state_o), 0);
    chk("sim_exit_modeS", int'(modeS), 1);
    $display("simultaneous events: state=%0d cnt=%0d", state_o, err_cnt);

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
